// File: rtl/reg_alu_seq_pkg.sv
// Shared definitions for the register-file sequencer around the 16-bit ripple ALU.
package reg_alu_seq_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_AW    = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } state_t;

    // Only arithmetic ops produce a meaningful carry.
    function automatic logic op_sets_carry(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/reg_alu_seq_reg_bank.sv
// Register array: one write port, three combinational read ports, async active-high reset.
module reg_alu_seq_reg_bank #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr1,
    input  logic [AW-1:0]    i_raddr2,
    input  logic [AW-1:0]    i_raddr3,
    output logic [WIDTH-1:0] o_rdata1,
    output logic [WIDTH-1:0] o_rdata2,
    output logic [WIDTH-1:0] o_rdata3
);

    logic [WIDTH-1:0] r_regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];
    assign o_rdata3 = r_regs[i_raddr3];

endmodule

// File: rtl/reg_alu_seq.sv
// Four-state sequencer: accept, read operands, let the ripple ALU settle, write back.
module reg_alu_seq
    import reg_alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [1:0]       ins_op,
    input  logic [AW-1:0]    ins_rd,
    input  logic [AW-1:0]    ins_rs1,
    input  logic [AW-1:0]    ins_rs2,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic             ld_drop,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_cout,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_flag
);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_op;
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_rs1;
    logic [AW-1:0]    r_rs2;
    logic             w_idle;
    logic             w_accept;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rs1_data;
    logic [WIDTH-1:0] w_rs2_data;

    assign w_idle    = (r_state == S_IDLE);
    assign ins_ready = w_idle && !ld_en;
    assign w_accept  = ins_valid && ins_ready;
    assign ld_drop   = ld_en && !w_idle;
    assign done      = (r_state == S_WB);

    // Host loads only land in IDLE; write-back owns the port in WB.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = ld_addr;
        w_wdata = ld_data;
        if (done) begin
            w_we    = 1'b1;
            w_waddr = r_rd;
            w_wdata = alu_o;
        end else if (w_idle && ld_en) begin
            w_we = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_READ;
            S_READ: w_state_next = S_EXEC;
            S_EXEC: w_state_next = S_WB;
            S_WB:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_ADD;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            alu_op  <= OP_ADD;
            alu_a   <= '0;
            alu_b   <= '0;
            result  <= '0;
            c_flag  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op  <= ins_op;
                r_rd  <= ins_rd;
                r_rs1 <= ins_rs1;
                r_rs2 <= ins_rs2;
            end
            if (r_state == S_READ) begin
                alu_a  <= w_rs1_data;
                alu_b  <= w_rs2_data;
                alu_op <= r_op;
            end
            if (done) begin
                result <= alu_o;
                if (op_sets_carry(r_op)) begin
                    c_flag <= alu_cout;
                end
            end
        end
    end

    reg_alu_seq_reg_bank #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_reg_bank (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr1 (r_rs1),
        .i_raddr2 (r_rs2),
        .i_raddr3 (rb_addr),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data),
        .o_rdata3 (rb_data)
    );

endmodule

// File: tb/tb_reg_alu_seq.sv
// Scoreboard bench for reg_alu_seq with a behavioural ripple-ALU stand-in.
module tb_reg_alu_seq;
    import reg_alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ins_valid, ins_ready;
    logic [1:0]  ins_op;
    logic [2:0]  ins_rd, ins_rs1, ins_rs2;
    logic        ld_en, ld_drop;
    logic [2:0]  ld_addr, rb_addr;
    logic [15:0] ld_data, rb_data;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_o, result;
    logic        alu_cout, done, c_flag;

    reg_alu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_op    (ins_op),
        .ins_rd    (ins_rd),
        .ins_rs1   (ins_rs1),
        .ins_rs2   (ins_rs2),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_drop   (ld_drop),
        .rb_addr   (rb_addr),
        .rb_data   (rb_data),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_o     (alu_o),
        .alu_cout  (alu_cout),
        .done      (done),
        .result    (result),
        .c_flag    (c_flag)
    );

    always #5 clk = ~clk;

    // External ALU: sub is a + ~b + 1, logic ops give no carry.
    always_comb begin
        logic [16:0] s;
        s = '0;
        case (alu_op)
            OP_ADD:  s = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  s = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
            OP_AND:  s = {1'b0, alu_a & alu_b};
            default: s = {1'b0, alu_a | alu_b};
        endcase
        alu_o    = s[15:0];
        alu_cout = s[16];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] res;
        logic        cf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: done pops an entry; committed result/flag checked one cycle later.
    always @(negedge clk) begin
        if (pend) begin
            chk("wb_result", {16'd0, result}, {16'd0, cur.res});
            chk("wb_cflag", {31'd0, c_flag}, {31'd0, cur.cf});
            pend = 1'b0;
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                cur = sb.pop_front();
                chk("done_latency", cyc, cur.cyc);
                pend = 1'b1;
            end
        end
    end

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] res, input logic cf,
                         input bit push, output int acc);
        int n = 0;
        @(negedge clk);
        ins_valid = 1'b1; ins_op = op; ins_rd = rd; ins_rs1 = rs1; ins_rs2 = rs2;
        #1;
        while (!ins_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!ins_ready) begin
            chk("accept_timeout", {31'd0, ins_ready}, 32'd1);
            ins_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        if (push) sb.push_back('{res, cf, cyc + 2});
        @(negedge clk);
        ins_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk); #2; n++;
        end while ((sb.size() != 0 || pend) && n < 50);
        if (sb.size() != 0 || pend) chk("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic chk_rb(input string name, input logic [2:0] a, input logic [15:0] exp);
        rb_addr = a;
        #1;
        chk(name, {16'd0, rb_data}, {16'd0, exp});
    endtask

    initial begin
        int a1, a2;
        reset = 1'b1; ins_valid = 1'b0; ins_op = '0; ins_rd = '0; ins_rs1 = '0; ins_rs2 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rb_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, ins_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cflag", {31'd0, c_flag}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
        chk("rst_alu_op", {30'd0, alu_op}, 32'd0);
        chk("rst_ld_drop", {31'd0, ld_drop}, 32'd0);
        for (int i = 0; i < 8; i++) chk_rb("rst_reg", i[2:0], 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Basic add
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0008, 1'b0, 1'b1, a1);
        wait_idle();
        chk_rb("add_rb3", 3'd3, 16'h0008);

        // Carry out, then subtract with borrow
        load(3'd1, 16'hFFFF);
        load(3'd2, 16'h0001);
        issue(OP_ADD, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b1, a1);
        issue(OP_SUB, 3'd5, 3'd2, 3'd1, 16'h0002, 1'b0, 1'b1, a1);
        wait_idle();
        chk_rb("add_wrap_rb4", 3'd4, 16'h0000);
        chk_rb("sub_rb5", 3'd5, 16'h0002);

        // Logic ops keep c_flag (set to 1 by the add first)
        load(3'd1, 16'hF0F0);
        load(3'd2, 16'h0FF0);
        issue(OP_ADD, 3'd7, 3'd1, 3'd1, 16'hE1E0, 1'b1, 1'b1, a1);
        issue(OP_AND, 3'd6, 3'd1, 3'd2, 16'h00F0, 1'b1, 1'b1, a1);
        issue(OP_OR, 3'd7, 3'd1, 3'd2, 16'hFFF0, 1'b1, 1'b1, a1);
        wait_idle();
        chk_rb("and_rb6", 3'd6, 16'h00F0);
        chk_rb("or_rb7", 3'd7, 16'hFFF0);
        chk("alu_a_held", {16'd0, alu_a}, 32'h0000F0F0);

        // rd = rs1 = rs2, back-to-back
        load(3'd1, 16'h4000);
        issue(OP_ADD, 3'd1, 3'd1, 3'd1, 16'h8000, 1'b0, 1'b1, a1);
        issue(OP_ADD, 3'd1, 3'd1, 3'd1, 16'h0000, 1'b1, 1'b1, a2);
        chk("b2b_spacing", a2 - a1, 32'd4);
        wait_idle();
        chk_rb("hazard_rb1", 3'd1, 16'h0000);

        // Load has priority over a same-cycle instruction
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'h1234;
        ins_valid = 1'b1; ins_op = OP_ADD; ins_rd = 3'd3; ins_rs1 = 3'd2; ins_rs2 = 3'd2;
        #1;
        chk("ld_blocks_ready", {31'd0, ins_ready}, 32'd0);
        @(negedge clk);
        ld_en = 1'b0;
        chk_rb("ld_prio_rb2", 3'd2, 16'h1234);
        chk("ready_after_ld", {31'd0, ins_ready}, 32'd1);
        @(posedge clk); #1;
        sb.push_back('{16'h2468, 1'b0, cyc + 2});
        @(negedge clk);
        ins_valid = 1'b0;
        wait_idle();
        chk_rb("ld_prio_rb3", 3'd3, 16'h2468);

        // Load during EXEC is dropped
        issue(OP_ADD, 3'd5, 3'd2, 3'd2, 16'h2468, 1'b0, 1'b1, a1);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'hBEEF;
        #1;
        chk("ld_drop_exec", {31'd0, ld_drop}, 32'd1);
        @(negedge clk);
        ld_en = 1'b0;
        #1;
        chk("ld_drop_clear", {31'd0, ld_drop}, 32'd0);
        chk_rb("ld_drop_rb2", 3'd2, 16'h1234);
        wait_idle();

        // Reset in EXEC aborts the operation
        load(3'd1, 16'hFFFF);
        issue(OP_ADD, 3'd6, 3'd1, 3'd1, 16'hFFFE, 1'b1, 1'b1, a1);
        wait_idle();
        issue(OP_ADD, 3'd7, 3'd1, 3'd1, 16'hFFFE, 1'b1, 1'b0, a1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_cflag", {31'd0, c_flag}, 32'd0);
        chk("abort_ready", {31'd0, ins_ready}, 32'd1);
        chk_rb("abort_rb6", 3'd6, 16'h0000);
        chk_rb("abort_rb1", 3'd1, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("post_rst_ready", {31'd0, ins_ready}, 32'd1);
        chk_rb("post_rst_rb7", 3'd7, 16'h0000);

        // Sub without borrow after reset
        load(3'd1, 16'h0007);
        load(3'd2, 16'h0002);
        issue(OP_SUB, 3'd0, 3'd1, 3'd2, 16'h0005, 1'b1, 1'b1, a1);
        wait_idle();
        chk_rb("sub_rb0", 3'd0, 16'h0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
